credit_sender: RTL and testbench

//   Upstream partner of the credit receiver on a credit-flow-controlled link.

---
 rtl/credit_sender.sv | 108 ++++++++++
 tb/tb_credit_sender.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// ---------------------------------------------------------------------------
// credit_sender
//   Upstream end of a credit-flow-controlled link. Takes beats from a local
//   producer over valid/ready and drives them onto the link through a single
//   register stage. One credit is spent per beat sent. One credit is regained
//   per cycle that pop_credit is high. Reset status is exchanged with the
//   receiver so that both ends restart from a known credit count.
//
// Ports
//   clk                    clock
//   rst_n                  asynchronous reset, active-low
//   push_valid/ready/data  producer side (ready has no dependency on valid)
//   pop_sender_in_reset    to receiver: this side is still in reset
//   pop_receiver_in_reset  from receiver: far side is in reset
//   pop_valid/pop_data     registered link beat
//   pop_credit             credit return, one credit per high cycle
//   credit_initial         count loaded every edge while either side is in reset
//   credit_withhold        credits held in reserve (not spendable)
//   credit_count           current credit count
//   credit_available       credit_count > credit_withhold
//   credit_error           sticky: credit returned at the ceiling with no send
// ---------------------------------------------------------------------------
module credit_sender #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_CREDITS  = 4,
    parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    pop_sender_in_reset,
    input  logic                    pop_receiver_in_reset,
    output logic                    pop_valid,
    output logic [DATA_WIDTH-1:0]   pop_data,
    input  logic                    pop_credit,
    input  logic [CREDIT_WIDTH-1:0] credit_initial,
    input  logic [CREDIT_WIDTH-1:0] credit_withhold,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_available,
    output logic                    credit_error
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_COUNT = CREDIT_WIDTH'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ONE       = CREDIT_WIDTH'(1);

    logic in_reset;
    logic send;

    // Either end being in reset freezes traffic and reloads the credit count.
    assign in_reset         = pop_sender_in_reset | pop_receiver_in_reset;
    assign credit_available = (credit_count > credit_withhold);
    assign push_ready       = credit_available & ~in_reset;
    assign send             = push_valid & push_ready;

    // Held high through reset and for the first edge after release, so the
    // first edge out of reset still loads credit_initial.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_sender_in_reset <= 1'b1;
        end else begin
            pop_sender_in_reset <= 1'b0;
        end
    end

    // Link register stage: one cycle latency, back-to-back sends allowed.
    // send is already gated by in_reset, so a receiver reset drops pop_valid
    // on the next edge and any registered beat is shown for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= send;
            if (send) begin
                pop_data <= push_data;
            end
        end
    end

    // Credit counter. Underflow cannot happen because send requires
    // count > withhold >= 0. A return at the ceiling without a matching
    // send is dropped and latched as an error until rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_count <= '0;
            credit_error <= 1'b0;
        end else if (in_reset) begin
            credit_count <= credit_initial;
        end else begin
            unique case ({send, pop_credit})
                2'b10: credit_count <= credit_count - ONE;
                2'b01: begin
                    if (credit_count >= MAX_COUNT) begin
                        credit_error <= 1'b1;
                    end else begin
                        credit_count <= credit_count + ONE;
                    end
                end
                default: ; // no change, or spend and return cancel out
            endcase
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
module tb_credit_sender;

    localparam int DW  = 8;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_credit;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic          credit_available;
    logic          credit_error;

    int errors = 0;
    int checks = 0;

    credit_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(MAX)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .push_valid            (push_valid),
        .push_ready            (push_ready),
        .push_data             (push_data),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .pop_credit            (pop_credit),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_error          (credit_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One directed step: inputs applied, push_ready checked before the edge,
    // registered outputs checked just after it.
    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          rir;
        logic          pc;
        logic [CW-1:0] init;
        logic [CW-1:0] wh;
        logic          e_ready;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_count;
        logic          e_err;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pv, input logic [DW-1:0] pd, input logic rir,
                                input logic pc, input logic [CW-1:0] init, input logic [CW-1:0] wh,
                                input logic e_ready, input logic e_valid, input logic [DW-1:0] e_data,
                                input logic [CW-1:0] e_count, input logic e_err);
        vec_t v;
        v.pv = pv; v.pd = pd; v.rir = rir; v.pc = pc; v.init = init; v.wh = wh;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data;
        v.e_count = e_count; v.e_err = e_err;
        return v;
    endfunction

    // Behavioural reference model state
    int            m_credits;
    bit            m_err;
    bit            m_srst;
    bit            m_valid;
    logic [DW-1:0] m_data;

    initial begin
        //          pv  pd     rir pc init wh  rdy val data   cnt err
        // reset release with initial=2
        vecs[0]  = mk(0, 8'h00, 0, 0, 2, 0,  0, 0, 8'h00, 2, 0);
        // two back-to-back sends drain the credits
        vecs[1]  = mk(1, 8'hA1, 0, 0, 2, 0,  1, 1, 8'hA1, 1, 0);
        vecs[2]  = mk(1, 8'hB2, 0, 0, 2, 0,  1, 1, 8'hB2, 0, 0);
        vecs[3]  = mk(1, 8'hC3, 0, 0, 2, 0,  0, 0, 8'hB2, 0, 0);
        // credit return, then send+credit in one cycle
        vecs[4]  = mk(0, 8'h00, 0, 1, 2, 0,  0, 0, 8'hB2, 1, 0);
        vecs[5]  = mk(1, 8'hD4, 0, 1, 2, 0,  1, 1, 8'hD4, 1, 0);
        // fill up to the ceiling and overflow
        vecs[6]  = mk(0, 8'h00, 0, 1, 2, 0,  1, 0, 8'hD4, 2, 0);
        vecs[7]  = mk(0, 8'h00, 0, 1, 2, 0,  1, 0, 8'hD4, 3, 0);
        vecs[8]  = mk(0, 8'h00, 0, 1, 2, 0,  1, 0, 8'hD4, 4, 0);
        vecs[9]  = mk(0, 8'h00, 0, 1, 2, 0,  1, 0, 8'hD4, 4, 1);
        vecs[10] = mk(0, 8'h00, 0, 0, 2, 0,  1, 0, 8'hD4, 4, 1);
        // drain to one credit, then withhold it
        vecs[11] = mk(1, 8'h11, 0, 0, 2, 0,  1, 1, 8'h11, 3, 1);
        vecs[12] = mk(1, 8'h22, 0, 0, 2, 0,  1, 1, 8'h22, 2, 1);
        vecs[13] = mk(1, 8'h33, 0, 0, 2, 0,  1, 1, 8'h33, 1, 1);
        vecs[14] = mk(1, 8'h44, 0, 0, 2, 1,  0, 0, 8'h33, 1, 1);
        vecs[15] = mk(1, 8'h55, 0, 0, 2, 0,  1, 1, 8'h55, 0, 1);
        // receiver reset mid-stream with initial=3
        vecs[16] = mk(0, 8'h00, 0, 1, 2, 0,  0, 0, 8'h55, 1, 1);
        vecs[17] = mk(0, 8'h00, 0, 1, 2, 0,  1, 0, 8'h55, 2, 1);
        vecs[18] = mk(1, 8'h66, 0, 0, 2, 0,  1, 1, 8'h66, 1, 1);
        vecs[19] = mk(1, 8'h77, 1, 0, 3, 0,  0, 0, 8'h66, 3, 1);
        vecs[20] = mk(1, 8'h78, 1, 1, 3, 0,  0, 0, 8'h66, 3, 1);
        vecs[21] = mk(1, 8'h88, 0, 0, 3, 0,  1, 1, 8'h88, 2, 1);
        vecs[22] = mk(0, 8'h00, 0, 0, 3, 0,  1, 0, 8'h88, 2, 1);

        rst_n                 = 1'b0;
        push_valid            = 1'b0;
        push_data             = '0;
        pop_receiver_in_reset = 1'b0;
        pop_credit            = 1'b0;
        credit_initial        = CW'(2);
        credit_withhold       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sender_in_reset", 32'(pop_sender_in_reset), 32'd1);
        check("rst_pop_valid",       32'(pop_valid),           32'd0);
        check("rst_pop_data",        32'(pop_data),            32'd0);
        check("rst_count",           32'(credit_count),        32'd0);
        check("rst_error",           32'(credit_error),        32'd0);
        check("rst_push_ready",      32'(push_ready),          32'd0);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            push_valid            = vecs[i].pv;
            push_data             = vecs[i].pd;
            pop_receiver_in_reset = vecs[i].rir;
            pop_credit            = vecs[i].pc;
            credit_initial        = vecs[i].init;
            credit_withhold       = vecs[i].wh;
            #1;
            check($sformatf("vec%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pop_valid", i), 32'(pop_valid),    32'(vecs[i].e_valid));
            check($sformatf("vec%0d_pop_data", i),  32'(pop_data),     32'(vecs[i].e_data));
            check($sformatf("vec%0d_count", i),     32'(credit_count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_error", i),     32'(credit_error), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_sender_rst", i), 32'(pop_sender_in_reset), 32'd0);
        end

        // withheld count is kept while push_ready is low
        credit_withhold = CW'(2);
        push_valid      = 1'b1;
        #1;
        check("withhold_avail_low", 32'(credit_available), 32'd0);
        check("withhold_ready_low", 32'(push_ready),        32'd0);
        @(posedge clk);
        #1;
        check("withhold_count_kept", 32'(credit_count), 32'd2);
        check("withhold_no_send",    32'(pop_valid),    32'd0);
        push_valid      = 1'b0;
        credit_withhold = '0;

        // ---------------- async reset mid-cycle clears the sticky error ------
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_error", 32'(credit_error),        32'd0);
        check("async_rst_count", 32'(credit_count),        32'd0);
        check("async_rst_srst",  32'(pop_sender_in_reset), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_credits = 0;
        m_err     = 1'b0;
        m_srst    = 1'b1;
        m_valid   = 1'b0;
        m_data    = '0;

        // ---------------- randomized run against the model ----------------
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit in_rst, exp_avail, exp_ready, do_send;
            push_valid            = 1'($urandom_range(1, 0));
            push_data             = DW'($urandom);
            pop_credit            = 1'($urandom_range(1, 0));
            pop_receiver_in_reset = ($urandom_range(15, 0) == 0);
            credit_initial        = CW'($urandom_range(MAX, 0));
            credit_withhold       = CW'($urandom_range(3, 0) == 0 ? $urandom_range(MAX, 0) : 0);
            #1;
            in_rst    = m_srst || pop_receiver_in_reset;
            exp_avail = (m_credits > int'(credit_withhold));
            exp_ready = exp_avail && !in_rst;
            do_send   = push_valid && exp_ready;
            check("rnd_credit_available", 32'(credit_available), 32'(exp_avail));
            check("rnd_push_ready",       32'(push_ready),       32'(exp_ready));

            // Spec rules applied to the abstract credit balance.
            if (in_rst) begin
                m_credits = int'(credit_initial);
                m_valid   = 1'b0;
            end else begin
                m_valid = do_send;
                if (do_send) m_data = push_data;
                if (pop_credit && !do_send && m_credits == MAX) begin
                    m_err = 1'b1;
                end else begin
                    m_credits = m_credits - int'(do_send) + int'(pop_credit);
                end
            end
            m_srst = 1'b0;

            @(posedge clk);
            #1;
            check("rnd_pop_valid",  32'(pop_valid),           32'(m_valid));
            check("rnd_pop_data",   32'(pop_data),            32'(m_data));
            check("rnd_count",      32'(credit_count),        32'(m_credits));
            check("rnd_error",      32'(credit_error),        32'(m_err));
            check("rnd_sender_rst", 32'(pop_sender_in_reset), 32'(m_srst));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
